mem_port_arbiter: RTL

Arbitrates the single data-memory port between the pipeline MEM stage and an external loader/debug requester (boot image load, memory inspection). It drives the data memory's address, write data, store-byte, write-enable and read-enable lines, and stalls the pipeline when it loses arbitration. It also rejects misaligned and out-of-range accesses before they reach memory. It sits between the EXE/MEM pipeline register and the data memory.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the MEM stage and an external loader/debug requester.
// Build option: define MEM_ARB_FAIRNESS_EN to force a loader grant after MAX_PIPE_BURST contended pipeline wins.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int MEM_BYTES      = 1024,
    parameter int MAX_PIPE_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic              pipe_byte,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [31:0]       pipe_wdata,
    output logic [31:0]       pipe_rdata,
    output logic              pipe_stall,
    output logic              pipe_fault,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic              ld_byte,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    input  logic              ld_lock,
    output logic              ld_ack,
    output logic              ld_err,
    output logic [31:0]       ld_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_store_byte,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PIPE = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(MEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] BYTE_END  = ADDR_W'(MEM_BYTES);

    if (MAX_PIPE_BURST < 1) begin : g_bad_burst
        $error("mem_port_arbiter: MAX_PIPE_BURST must be at least 1");
    end
    if (MEM_BYTES < 4) begin : g_bad_size
        $error("mem_port_arbiter: MEM_BYTES must hold at least one word");
    end

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              lock_hold;
    logic              force_ld;
    logic              grant_ld;
    logic              grant_pipe;
    logic              any_grant;
    logic              sel_we;
    logic              sel_byte;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_fault;
    logic              ld_vld_p1;
    logic              ld_err_p1;
    logic              pipe_fault_p1;
    logic [31:0]       ld_rdata_p1;

    function automatic logic access_fault(input logic [ADDR_W-1:0] addr, input logic is_byte);
        if (is_byte)
            return addr >= BYTE_END;
        return (addr[1:0] != 2'b00) || (addr > WORD_LAST);
    endfunction

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_PIPE_BURST + 1);

    logic [CNT_W-1:0] burst_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_W'(MAX_PIPE_BURST)) ? v : v + 1'b1;
    endfunction

    assign force_ld = (burst_cnt == CNT_W'(MAX_PIPE_BURST));

    // Counts only contended pipeline wins; any idle loader cycle restarts the window.
    always_ff @(posedge clk) begin
        if (rst)
            burst_cnt <= '0;
        else if (grant_ld || !ld_req)
            burst_cnt <= '0;
        else if (grant_pipe)
            burst_cnt <= sat_inc(burst_cnt);
    end
`else
    assign force_ld = 1'b0;
`endif

    // Held lock excludes the pipeline even while the loader is not requesting.
    assign lock_hold  = (state == S_LOCK) && ld_lock;
    assign grant_ld   = ld_req && (lock_hold || !pipe_req || force_ld);
    assign grant_pipe = pipe_req && !lock_hold && !grant_ld;
    assign any_grant  = grant_ld || grant_pipe;

    always_comb begin
        sel_we    = 1'b0;
        sel_byte  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant_ld) begin
            sel_we    = ld_we;
            sel_byte  = ld_byte;
            sel_addr  = ld_addr;
            sel_wdata = ld_wdata;
        end else if (grant_pipe) begin
            sel_we    = pipe_we;
            sel_byte  = pipe_byte;
            sel_addr  = pipe_addr;
            sel_wdata = pipe_wdata;
        end
    end

    assign sel_fault = access_fault(sel_addr, sel_byte);

    assign mem_addr       = sel_addr;
    assign mem_wdata      = sel_wdata;
    assign mem_store_byte = sel_byte;
    assign mem_write      = any_grant && !sel_fault && sel_we;
    assign mem_read       = any_grant && !sel_fault && !sel_we;

    assign pipe_rdata = mem_rdata;
    assign pipe_stall = pipe_req && !grant_pipe;

    always_comb begin
        state_nxt = S_IDLE;
        if (grant_ld)
            state_nxt = ld_lock ? S_LOCK : S_LOAD;
        else if (grant_pipe)
            state_nxt = S_PIPE;
        else if (lock_hold)
            state_nxt = S_LOCK;
    end

    // Stage p0 -> p1: grant cycle to loader acknowledge / pipeline fault report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ld_vld_p1     <= 1'b0;
            ld_err_p1     <= 1'b0;
            pipe_fault_p1 <= 1'b0;
        end else begin
            state         <= state_nxt;
            ld_vld_p1     <= grant_ld;
            ld_err_p1     <= grant_ld && sel_fault;
            pipe_fault_p1 <= grant_pipe && sel_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ld_rdata_p1 <= '0;
        else if (grant_ld && !ld_we)
            ld_rdata_p1 <= mem_rdata;
    end

    assign ld_ack     = ld_vld_p1;
    assign ld_err     = ld_err_p1;
    assign ld_rdata   = ld_rdata_p1;
    assign pipe_fault = pipe_fault_p1;

endmodule
